bp_be_accel_wb_drain: RTL and testbench

BP_BE_ACCEL_WB_DRAIN -- requirements
Module: bp_be_accel_wb_drain

---
 rtl/bp_be_pkg.sv | 5 +
 rtl/bp_be_accel_wb_drain_if.sv | 24 ++
 rtl/bsg_counter_up_down.sv | 15 +
 rtl/bp_be_accel_wb_drain.sv | 74 +++++++
 tb/tb_bp_be_accel_wb_drain.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared drain FSM states and store stride for the accelerator writeback path
package bp_be_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} wb_state_e;
  localparam int stride_bytes_lp = 16;
endpackage

// File: rtl/bp_be_accel_wb_drain_if.sv
// bp_be_accel_wb_drain_if: result-beat input plus uncached store and write-ack channels
interface bp_be_accel_wb_drain_if #(
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 128
);
  logic                     in_v_i;
  logic                     in_buf_i;
  logic [data_width_p-1:0]  in_data_i;
  logic                     in_ready_o;
  logic [paddr_width_p-1:0] mem_fwd_addr_o;
  logic [data_width_p-1:0]  mem_fwd_data_o;
  logic                     mem_fwd_v_o;
  logic                     mem_fwd_ready_and_i;
  logic                     mem_rev_v_i;
  logic                     mem_rev_ready_and_o;
  modport master (
    input  in_v_i, in_buf_i, in_data_i, mem_fwd_ready_and_i, mem_rev_v_i,
    output in_ready_o, mem_fwd_addr_o, mem_fwd_data_o, mem_fwd_v_o, mem_rev_ready_and_o
  );
  modport slave (
    output in_v_i, in_buf_i, in_data_i, mem_fwd_ready_and_i, mem_rev_v_i,
    input  in_ready_o, mem_fwd_addr_o, mem_fwd_data_o, mem_fwd_v_o, mem_rev_ready_and_o
  );
endinterface

// File: rtl/bsg_counter_up_down.sv
// bsg_counter_up_down: up/down counter; caller guarantees it never steps past 0 or max_val_p
module bsg_counter_up_down #(
  parameter int max_val_p = 4,
  parameter int width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                up_i,
  input  logic                down_i,
  output logic [width_lp-1:0] count_o
);
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) count_o <= '0;
    else            count_o <= count_o + width_lp'(up_i) - width_lp'(down_i);
endmodule

// File: rtl/bp_be_accel_wb_drain.sv
// bp_be_accel_wb_drain: turns DPU result beats into credited 16-byte uncached stores and drains them on fence
module bp_be_accel_wb_drain
  import bp_be_pkg::*;
#(
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 128,
  parameter int credits_p     = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     cfg_v_i,
  input  logic                     cfg_sel_i,
  input  logic [paddr_width_p-1:0] cfg_addr_i,
  bp_be_accel_wb_drain_if.master   bus,
  input  logic                     fence_v_i,
  output logic                     fence_done_o,
  output logic                     busy_o,
  output logic                     err_o
);
  localparam int cnt_w_lp = $clog2(credits_p + 1);
  wb_state_e                state_r, state_n;
  logic [paddr_width_p-1:0] ptr_r [2];
  logic [paddr_width_p-1:0] fwd_addr_r;
  logic [data_width_p-1:0]  fwd_data_r;
  logic                     fwd_v_r, err_r, accept, ack_ok;
  logic [cnt_w_lp-1:0]      credit_cnt;
  assign bus.in_ready_o = (state_r == RUN) & (credit_cnt < cnt_w_lp'(credits_p))
                        & (~fwd_v_r | bus.mem_fwd_ready_and_i);
  assign accept = bus.in_v_i & bus.in_ready_o;
  // an ack with nothing outstanding is flagged instead of underflowing the count
  assign ack_ok = bus.mem_rev_v_i & (credit_cnt != '0);
  assign bus.mem_rev_ready_and_o = 1'b1;
  assign bus.mem_fwd_v_o    = fwd_v_r;
  assign bus.mem_fwd_addr_o = fwd_addr_r;
  assign bus.mem_fwd_data_o = fwd_data_r;
  assign fence_done_o = (state_r == DONE);
  assign busy_o = (credit_cnt != '0) | fwd_v_r;
  assign err_o = err_r;
  bsg_counter_up_down #(.max_val_p(credits_p)) credit_ctr (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .up_i     (accept),
    .down_i   (ack_ok),
    .count_o  (credit_cnt)
  );
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      ptr_r[0]   <= '0;
      ptr_r[1]   <= '0;
      fwd_v_r    <= 1'b0;
      fwd_addr_r <= '0;
      fwd_data_r <= '0;
      err_r      <= 1'b0;
    end else begin
      if (accept) begin
        fwd_v_r               <= 1'b1;
        fwd_addr_r            <= ptr_r[bus.in_buf_i];
        fwd_data_r            <= bus.in_data_i;
        ptr_r[bus.in_buf_i]   <= ptr_r[bus.in_buf_i] + paddr_width_p'(stride_bytes_lp);
      end else if (bus.mem_fwd_ready_and_i) fwd_v_r <= 1'b0;
      // a same-cycle config write overrides the post-accept increment
      if (cfg_v_i) ptr_r[cfg_sel_i] <= cfg_addr_i;
      if (bus.mem_rev_v_i && credit_cnt == '0) err_r <= 1'b1;
    end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_r <= RUN;
    else            state_r <= state_n;
  always_comb begin
    state_n = state_r;
    state_n = (state_r == RUN && fence_v_i) ? DRAIN
            : (state_r == DRAIN && credit_cnt == '0 && !fwd_v_r) ? DONE
            : (state_r == DONE) ? RUN : state_r;
  end
endmodule

// File: tb/tb_bp_be_accel_wb_drain.sv
// tb_bp_be_accel_wb_drain: directed vectors checked against a queue-based transaction model plus literal pins
module tb_bp_be_accel_wb_drain;
  localparam int AW = 40;
  localparam int DW = 128;
  localparam int CR = 4;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} beat_t;
  logic clk = 1'b0, reset_n = 1'b1;
  logic cfg_v = 0, cfg_sel = 0, in_v = 0, in_buf = 0, fwd_rdy = 1, rev_v = 0, fence_v = 0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic fence_done, busy, err;
  int vectors = 0, miscompares = 0;
  bp_be_accel_wb_drain_if #(.paddr_width_p(AW), .data_width_p(DW)) bus ();
  assign bus.in_v_i = in_v;
  assign bus.in_buf_i = in_buf;
  assign bus.in_data_i = in_data;
  assign bus.mem_fwd_ready_and_i = fwd_rdy;
  assign bus.mem_rev_v_i = rev_v;
  bp_be_accel_wb_drain #(.paddr_width_p(AW), .data_width_p(DW), .credits_p(CR)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .cfg_v_i(cfg_v), .cfg_sel_i(cfg_sel), .cfg_addr_i(cfg_addr),
    .bus(bus), .fence_v_i(fence_v), .fence_done_o(fence_done), .busy_o(busy), .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // transaction model: pointers, pending-store queue, outstanding writes, fence progress
  logic [AW-1:0] m_ptr [2];
  beat_t q [$];
  int m_out;
  bit m_err, m_fencing, m_done;
  function automatic bit m_ready();
    return !m_fencing && !m_done && m_out < CR && (q.size() == 0 || fwd_rdy);
  endfunction
  always @(posedge clk) begin
    if (!reset_n) begin
      m_ptr[0] = '0; m_ptr[1] = '0; q.delete(); m_out = 0;
      m_err = 0; m_fencing = 0; m_done = 0;
    end else begin
      automatic bit acc = in_v && m_ready();
      automatic bit drained = (m_out == 0) && (q.size() == 0);
      if (q.size() != 0 && fwd_rdy) void'(q.pop_front());
      if (acc) begin
        q.push_back('{a: m_ptr[in_buf], d: in_data});
        m_ptr[in_buf] = m_ptr[in_buf] + 16;
      end
      if (cfg_v) m_ptr[cfg_sel] = cfg_addr;
      if (rev_v) begin
        if (m_out == 0) m_err = 1; else m_out--;
      end
      if (acc) m_out++;
      if (m_done) m_done = 0;
      else if (m_fencing) begin
        if (drained) begin m_fencing = 0; m_done = 1; end
      end else if (fence_v) m_fencing = 1;
    end
  end
  always @(negedge clk) if (reset_n) begin
    chk("in_ready", bus.in_ready_o, m_ready());
    chk("fwd_v", bus.mem_fwd_v_o, q.size() != 0);
    if (q.size() != 0) begin
      chk("fwd_addr", bus.mem_fwd_addr_o, q[0].a);
      chk("fwd_data", bus.mem_fwd_data_o, q[0].d);
    end
    chk("busy", busy, m_out != 0 || q.size() != 0);
    chk("fence_done", fence_done, m_done);
    chk("err", err, m_err);
    chk("rev_ready", bus.mem_rev_ready_and_o, 1'b1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic acks(input int n);
    rev_v = 1;
    repeat (n) tick();
    rev_v = 0;
  endtask
  initial begin
    int acc_n;
    #2 reset_n = 0;
    tick();
    chk("rst_in_ready", bus.in_ready_o, 1'b1);
    chk("rst_fwd_v", bus.mem_fwd_v_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_fence_done", fence_done, 1'b0);
    tick();
    reset_n = 1;
    tick();
    // three consecutive beats from ptr0
    cfg_v = 1; cfg_sel = 0; cfg_addr = 40'h00_8000_0000;
    tick();
    cfg_v = 0; in_v = 1; in_buf = 0;
    for (int i = 0; i < 3; i++) begin
      in_data = 128'hA0 + DW'(i);
      tick();
      chk("seq_addr", bus.mem_fwd_addr_o, 40'h00_8000_0000 + AW'(16 * i));
      chk("seq_v", bus.mem_fwd_v_o, 1'b1);
    end
    in_v = 0;
    tick();
    chk("seq_drained", bus.mem_fwd_v_o, 1'b0);
    acks(3);
    // credit exhaustion with acks withheld
    in_v = 1; acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      in_data = 128'hB0 + DW'(i);
      if (bus.in_ready_o) acc_n++;
      tick();
    end
    chk("credit_accepts", DW'(acc_n), DW'(4));
    chk("credit_stall", bus.in_ready_o, 1'b0);
    rev_v = 1;
    tick();
    rev_v = 0;
    chk("credit_reopen", bus.in_ready_o, 1'b1);
    tick();
    chk("fifth_v", bus.mem_fwd_v_o, 1'b1);
    chk("fifth_addr", bus.mem_fwd_addr_o, 40'h00_8000_0070);
    chk("refull", bus.in_ready_o, 1'b0);
    in_v = 0;
    acks(4);
    chk("credit_idle", busy, 1'b0);
    // ptr1 wrap at the top of the address space
    cfg_v = 1; cfg_sel = 1; cfg_addr = 40'hFF_FFFF_FFF0;
    tick();
    cfg_v = 0; in_v = 1; in_buf = 1; in_data = 128'hC0;
    tick();
    chk("wrap_hi", bus.mem_fwd_addr_o, 40'hFF_FFFF_FFF0);
    in_data = 128'hC1;
    tick();
    chk("wrap_lo", bus.mem_fwd_addr_o, 40'h0);
    in_v = 0; in_buf = 0;
    tick();
    acks(2);
    // fence with two writes outstanding
    in_v = 1; in_data = 128'hD0;
    tick();
    in_data = 128'hD1;
    tick();
    in_v = 0;
    tick();
    fence_v = 1;
    tick();
    fence_v = 0;
    chk("fence_block", bus.in_ready_o, 1'b0);
    chk("fence_busy", busy, 1'b1);
    acks(1);
    chk("fence_block2", bus.in_ready_o, 1'b0);
    acks(1);
    chk("fence_wait", fence_done, 1'b0);
    tick();
    chk("fence_pulse", fence_done, 1'b1);
    chk("fence_pulse_block", bus.in_ready_o, 1'b0);
    tick();
    chk("fence_end", fence_done, 1'b0);
    chk("fence_run", bus.in_ready_o, 1'b1);
    // idle fence, held high through DRAIN and DONE
    fence_v = 1;
    tick();
    chk("idle_fence0", fence_done, 1'b0);
    tick();
    chk("idle_fence1", fence_done, 1'b1);
    tick();
    fence_v = 0;
    chk("idle_fence2", fence_done, 1'b0);
    chk("idle_run", bus.in_ready_o, 1'b1);
    tick();
    chk("idle_no_retrig", fence_done, 1'b0);
    // spurious ack sets sticky error
    acks(1);
    chk("err_set", err, 1'b1);
    tick(); tick();
    chk("err_sticky", err, 1'b1);
    chk("err_busy", busy, 1'b0);
    // cfg and accept on ptr0 in the same cycle
    cfg_v = 1; cfg_sel = 0; cfg_addr = 40'h00_0000_1000;
    tick();
    cfg_addr = 40'h00_0000_5000; in_v = 1; in_data = 128'hE0;
    tick();
    cfg_v = 0; in_data = 128'hE1;
    chk("cfg_old", bus.mem_fwd_addr_o, 40'h00_0000_1000);
    tick();
    chk("cfg_new", bus.mem_fwd_addr_o, 40'h00_0000_5000);
    in_v = 0;
    tick();
    acks(2);
    // store backpressure holds payload
    fwd_rdy = 0; in_v = 1; in_data = 128'hF0;
    tick();
    in_data = 128'hF1;
    chk("bp_v", bus.mem_fwd_v_o, 1'b1);
    chk("bp_block", bus.in_ready_o, 1'b0);
    tick(); tick();
    chk("bp_addr", bus.mem_fwd_addr_o, 40'h00_0000_5010);
    chk("bp_data", bus.mem_fwd_data_o, 128'hF0);
    in_v = 0; fwd_rdy = 1;
    tick();
    acks(1);
    // reset mid-transfer drops the beat and clears error
    in_v = 1; in_data = 128'h99;
    tick();
    in_v = 0;
    reset_n = 0;
    #1;
    chk("mid_rst_v", bus.mem_fwd_v_o, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", bus.in_ready_o, 1'b1);
    chk("mid_rst_err", err, 1'b0);
    tick(); tick();
    reset_n = 1;
    tick();
    in_v = 1; in_data = 128'h77;
    tick();
    chk("post_rst_addr", bus.mem_fwd_addr_o, 40'h0);
    in_v = 0;
    tick();
    acks(1);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
